// File: rtl/riscv_data_mem.sv
// rtl/riscv_data_mem.sv - word-organised data memory for a RISC-V LSU with fixed access latency
//
// Purpose: single-port byte-enabled data RAM. Each request is latched, held for
// WAIT_STATES cycles, then committed with a one-cycle ready_o pulse.
// Optional feature macro: RISCV_DMEM_RANGE_CHK_EN (adds err_o and blocks out-of-range accesses).
//
// Ports:
//   clk_i    in   1  clock, rising edge
//   rst_i    in   1  asynchronous active-high reset
//   req_i    in   1  access request, held until ready_o
//   we_i     in   1  1 = write, 0 = read
//   be_i     in   4  byte-lane enables
//   addr_i   in  32  byte address
//   wd_i     in  32  lane-replicated write data
//   rd_o     out 32  last read word
//   ready_o  out  1  completion pulse
//   err_o    out  1  out-of-range flag, with ready_o (RISCV_DMEM_RANGE_CHK_EN only)

module riscv_data_mem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd_o,
    output logic        ready_o
`ifdef RISCV_DMEM_RANGE_CHK_EN
    ,
    output logic        err_o
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state;
    state_t          state_nx;
    logic [3:0]      cnt;
    logic            we_q;
    logic [3:0]      be_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wd_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic            commit;
    logic            acc_we;
    logic [3:0]      acc_be;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_wd;
    logic            acc_oor;

    // Only the word-index bits of the address select storage; the rest wrap.
    logic            unused_addr;
    assign unused_addr = ^{addr_i[1:0], addr_i[31:AW+2]};

    assign accept = (state == S_IDLE) && req_i && !rst_i;
    assign commit = (accept && (WAIT_STATES == 0)) ||
                    ((state == S_WAIT) && (cnt == 4'd0) && !rst_i);

    // With zero wait states the commit edge is the acceptance edge, so the
    // access fields come straight from the inputs instead of the latches.
    assign acc_we  = (state == S_IDLE) ? we_i            : we_q;
    assign acc_be  = (state == S_IDLE) ? be_i            : be_q;
    assign acc_idx = (state == S_IDLE) ? addr_i[AW+1:2]  : idx_q;
    assign acc_wd  = (state == S_IDLE) ? wd_i            : wd_q;

`ifdef RISCV_DMEM_RANGE_CHK_EN
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    logic oor_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            oor_q <= 1'b0;
        end else if (accept) begin
            oor_q <= ({1'b0, addr_i} >= ADDR_LIMIT);
        end
    end

    assign acc_oor = (state == S_IDLE) ? ({1'b0, addr_i} >= ADDR_LIMIT) : oor_q;
    assign err_o   = (state == S_RESP) && oor_q;
`else
    assign acc_oor = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (req_i) state_nx = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt == 4'd0) state_nx = S_RESP;
            S_RESP: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
        end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q  <= 1'b0;
            be_q  <= 4'd0;
            idx_q <= '0;
            wd_q  <= 32'd0;
        end else if (accept) begin
            we_q  <= we_i;
            be_q  <= be_i;
            idx_q <= addr_i[AW+1:2];
            wd_q  <= wd_i;
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk_i) begin
        if (commit && acc_we && !acc_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_o <= 32'd0;
        end else if (commit && !acc_we) begin
            rd_o <= acc_oor ? 32'd0 : mem[acc_idx];
        end
    end

    assign ready_o = (state == S_RESP);

endmodule

// File: tb/tb_riscv_data_mem.sv
// tb/tb_riscv_data_mem.sv - randomized self-checking bench for riscv_data_mem

module tb_riscv_data_mem;

    localparam int DEPTH  = 1024;
    localparam int WS     = 2;
    localparam int DEPTH0 = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [3:0]  be = 4'd0;
    logic [31:0] addr = 32'd0, wd = 32'd0;
    logic [31:0] rd;
    logic        ready;
    logic        req0 = 1'b0, we0 = 1'b0;
    logic [3:0]  be0 = 4'd0;
    logic [31:0] addr0 = 32'd0, wd0 = 32'd0;
    logic [31:0] rd0;
    logic        ready0;
`ifdef RISCV_DMEM_RANGE_CHK_EN
    logic        err, err0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: per-word contents plus which bytes have been written.
    logic [31:0] model_mem [DEPTH];
    logic [3:0]  known [DEPTH];
    logic [31:0] exp_rd = 32'd0;
    logic [3:0]  exp_known = 4'hF;

    always #5 clk = ~clk;

    riscv_data_mem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wd_i(wd), .rd_o(rd), .ready_o(ready)
`ifdef RISCV_DMEM_RANGE_CHK_EN
        , .err_o(err)
`endif
    );

    riscv_data_mem #(.DEPTH_WORDS(DEPTH0), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we0), .be_i(be0),
        .addr_i(addr0), .wd_i(wd0), .rd_o(rd0), .ready_o(ready0)
`ifdef RISCV_DMEM_RANGE_CHK_EN
        , .err_o(err0)
`endif
    );

    function automatic logic [31:0] lane_mask(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = k[b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    function automatic bit out_of_range(input logic [31:0] a);
`ifdef RISCV_DMEM_RANGE_CHK_EN
        return (a >> 2) >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    // One complete LSU transaction on the WAIT_STATES=2 instance, checked against the model.
    task automatic access(input logic w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] d, input bit scramble);
        int lat = 0;
        int i;
        bit oor;
        @(negedge clk);
        req = 1'b1; we = w; be = b; addr = a; wd = d;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ready) begin lat = n; break; end
            if (scramble) begin
                we = ~w; be = 4'($urandom); addr = $urandom; wd = $urandom;
            end
        end
        req = 1'b0;
        i   = int'((a >> 2) % DEPTH);
        oor = out_of_range(a);
        if (w) begin
            if (!oor) begin
                for (int k = 0; k < 4; k++) if (b[k]) begin
                    model_mem[i][8*k +: 8] = d[8*k +: 8];
                    known[i][k] = 1'b1;
                end
            end
        end else begin
            exp_rd    = oor ? 32'd0 : model_mem[i];
            exp_known = oor ? 4'hF : known[i];
        end
        checks++;
        if (lat != WS + 1) begin
            errors++;
            $display("FAIL latency addr=%h got=%0d expected=%0d", a, lat, WS + 1);
        end
        checks++;
        if ((rd & lane_mask(exp_known)) !== (exp_rd & lane_mask(exp_known))) begin
            errors++;
            $display("FAIL rd_data addr=%h we=%b got=%h expected=%h mask=%b", a, w, rd, exp_rd, exp_known);
        end
`ifdef RISCV_DMEM_RANGE_CHK_EN
        checks++;
        if (err !== oor) begin
            errors++;
            $display("FAIL err_flag addr=%h got=%b expected=%b", a, err, oor);
        end
`endif
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_pulse addr=%h got=%b expected=0", a, ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (ready !== 1'b0 || rd !== 32'd0 || ready0 !== 1'b0 || rd0 !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got ready=%b rd=%h ready0=%b rd0=%h expected 0/0/0/0", ready, rd, ready0, rd0);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        access(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1'b0, 4'b1111, 32'h10, 32'h0, 1'b0);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL full_word got=%h expected=deadbeef", rd);
        end
        access(1'b1, 4'b0100, 32'h10, 32'h00AA0000, 1'b0);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_keeps_rd got=%h expected=deadbeef", rd);
        end
        access(1'b0, 4'b0000, 32'h10, 32'h0, 1'b0);
        checks++;
        if (rd !== 32'hDEAABEEF) begin
            errors++;
            $display("FAIL byte_lane got=%h expected=deaabeef", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int k = 0; k < 16; k++) access(1'b1, 4'hF, 32'(k * 4), $urandom, 1'b0);
        for (int n = 0; n < 50; n++) begin
            a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
`ifndef RISCV_DMEM_RANGE_CHK_EN
            a = a + 32'($urandom_range(0, 7)) * 32'h1000;
`endif
            access(1'($urandom), 4'($urandom), a, $urandom, 1'b0);
        end
    endtask

    task automatic test_scramble();
        logic [31:0] v = $urandom;
        access(1'b1, 4'hF, 32'h40, v, 1'b1);
        access(1'b0, 4'hF, 32'h40, 32'h0, 1'b1);
        checks++;
        if (rd !== v) begin
            errors++;
            $display("FAIL latched_inputs got=%h expected=%h", rd, v);
        end
    endtask

    task automatic test_wrap();
`ifdef RISCV_DMEM_RANGE_CHK_EN
        access(1'b1, 4'hF, 32'h0, 32'hA5A5A5A5, 1'b0);
        access(1'b1, 4'hF, 32'h1000, 32'h55, 1'b0);
        access(1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
        checks++;
        if (rd !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL range_write got=%h expected=a5a5a5a5", rd);
        end
        access(1'b0, 4'hF, 32'h1000, 32'h0, 1'b0);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL range_read got=%h expected=0", rd);
        end
`else
        access(1'b1, 4'hF, 32'h1000, 32'h55, 1'b0);
        access(1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
        checks++;
        if (rd !== 32'h55) begin
            errors++;
            $display("FAIL wrap got=%h expected=55", rd);
        end
`endif
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        access(1'b1, 4'hF, 32'h20, 32'h0, 1'b0);
        access(1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h20; wd = 32'h12345678;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got ready=%b rd=%h expected 0/0", ready, rd);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_ready got=%0d pulses expected=0", pulses);
        end
        exp_rd = 32'h0;
        exp_known = 4'hF;
        access(1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
        checks++;
        if (rd === 32'h12345678) begin
            errors++;
            $display("FAIL abort_commit got=%h expected=0", rd);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; be0 = 4'hF; addr0 = 32'h4; wd0 = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if (ready0 !== 1'b1) begin
            errors++;
            $display("FAIL zero_wait_latency got=%b expected=1", ready0);
        end
        req0 = 1'b0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; wd0 = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if (ready0 !== 1'(k % 2)) begin
                errors++;
                $display("FAIL b2b_ready cycle=%0d got=%b expected=%b", k, ready0, 1'(k % 2));
            end
            if (ready0 === 1'b1) begin
                pulses++;
                checks++;
                if (rd0 !== 32'hCAFEF00D) begin
                    errors++;
                    $display("FAIL b2b_data cycle=%0d got=%h expected=cafef00d", k, rd0);
                end
            end
        end
        req0 = 1'b0;
        checks++;
        if (pulses != 10) begin
            errors++;
            $display("FAIL b2b_count got=%0d expected=10", pulses);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = 32'h0;
            known[i] = 4'h0;
        end
        test_reset();
        test_directed();
        test_random();
        test_scramble();
        test_wrap();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
